reg_file_cc: RTL and testbench

LC-3 datapath register file with condition-code and branch-enable state. Holds R0–R7 and drives the ALU's SR1/SR2 operands. Takes the 16-bit BUS result as its write data. Also registers N/Z/P from BUS and computes the registered BEN flag for the control unit's BR decision.

---
 rtl/lc3_pkg.sv | 18 +
 rtl/reg_file_cc_cc_unit.sv | 64 ++++++
 rtl/reg_file_cc.sv | 88 ++++++++
 tb/tb_reg_file_cc.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// lc3_pkg
// Shared LC-3 datapath types and constants. Imported by the register file,
// the condition-code unit, and reused by the ALU and control unit.
//
// Contents:
//   word_t      16-bit datapath word
//   reg_idx_t   3-bit general register index (R0..R7)
//   R7_IDX      index of R7, the JSR/TRAP link register
//   NZP_RESET   condition codes after reset ({N,Z,P} = Z)
package lc3_pkg;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  reg_idx_t;

  localparam reg_idx_t   R7_IDX    = 3'b111;
  localparam logic [2:0] NZP_RESET = 3'b010;

endpackage

// File: rtl/reg_file_cc_cc_unit.sv
// cc_unit
// Condition-code and branch-enable state for the LC-3 datapath.
// Decodes N/Z/P from the bus word and registers it on LD_CC; evaluates the
// BR condition against the registered NZP and registers it on LD_BEN.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   bus      in   datapath bus word (condition-code source)
//   ir_cond  in   IR[11:9], the n/z/p mask of a BR instruction
//   ld_cc    in   load NZP from bus this edge
//   ld_ben   in   load BEN this edge
//   nzp      out  registered {N,Z,P}
//   ben      out  registered branch enable
module cc_unit
  import lc3_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus,
  input  logic [2:0]       ir_cond,
  input  logic             ld_cc,
  input  logic             ld_ben,
  output logic [2:0]       nzp,
  output logic             ben
);

  logic [2:0] nzp_next;
  logic       bus_zero;
  logic       ben_next;

  // Exactly one of N/Z/P is set for any bus value: the sign bit wins for
  // negatives, zero is its own case, everything else is positive.
  always_comb begin
    nzp_next = 3'b000;
    bus_zero = (bus == '0);
    nzp_next = {bus[WIDTH-1], bus_zero, ~bus[WIDTH-1] & ~bus_zero};
  end

  // The branch decision uses the NZP already in the flops, so a CC load on
  // the same edge does not affect the BEN being captured.
  always_comb begin
    ben_next = (ir_cond[2] & nzp[2]) | (ir_cond[1] & nzp[1]) | (ir_cond[0] & nzp[0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzp <= NZP_RESET;
    end else if (ld_cc) begin
      nzp <= nzp_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ben <= 1'b0;
    end else if (ld_ben) begin
      ben <= ben_next;
    end
  end

endmodule

// File: rtl/reg_file_cc.sv
// reg_file_cc
// LC-3 general register file (R0..R7) with the condition-code / BEN state.
// Two combinational read ports feed the ALU; one write port takes the bus.
//
// Ports:
//   Clk      in   rising-edge clock
//   Reset_n  in   asynchronous active-low reset
//   BUS      in   datapath bus: register write data and CC source
//   IR       in   current instruction register
//   LD_REG   in   write BUS into the selected DR this edge
//   LD_CC    in   update NZP from BUS this edge
//   LD_BEN   in   update BEN this edge
//   DRMUX    in   DR select: 0 = IR[11:9], 1 = R7
//   SR1MUX   in   SR1 select: 0 = IR[11:9], 1 = IR[8:6]
//   SR1      out  read port 1
//   SR2      out  read port 2, index IR[2:0]
//   NZP      out  registered condition codes {N,Z,P}
//   BEN      out  registered branch enable
module reg_file_cc
  import lc3_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] BUS,
  input  logic [15:0]      IR,
  input  logic             LD_REG,
  input  logic             LD_CC,
  input  logic             LD_BEN,
  input  logic             DRMUX,
  input  logic             SR1MUX,
  output logic [WIDTH-1:0] SR1,
  output logic [WIDTH-1:0] SR2,
  output logic [2:0]       NZP,
  output logic             BEN
);

  logic [WIDTH-1:0] regs [NREGS];
  reg_idx_t         dr_idx;
  reg_idx_t         sr1_idx;
  reg_idx_t         sr2_idx;

  // Opcode and the middle operand field are decoded elsewhere.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{IR[15:12], IR[5:3]};

  // Register index selection. DRMUX=1 targets R7 for the link register.
  always_comb begin
    dr_idx  = DRMUX  ? R7_IDX   : IR[11:9];
    sr1_idx = SR1MUX ? IR[8:6]  : IR[11:9];
    sr2_idx = IR[2:0];
  end

  // Reads come straight from the array with no write bypass: a same-cycle
  // write to the addressed register only shows up after the edge.
  always_comb begin
    SR1 = regs[sr1_idx];
    SR2 = regs[sr2_idx];
  end

  // Single write port; reset clears every register asynchronously so no
  // partially-completed write can survive a mid-cycle reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (LD_REG) begin
      regs[dr_idx] <= BUS;
    end
  end

  cc_unit #(
    .WIDTH (WIDTH)
  ) u_cc (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .bus     (BUS),
    .ir_cond (IR[11:9]),
    .ld_cc   (LD_CC),
    .ld_ben  (LD_BEN),
    .nzp     (NZP),
    .ben     (BEN)
  );

endmodule

// File: tb/tb_reg_file_cc.sv
// tb_reg_file_cc
// Directed bench for reg_file_cc. Expected values are pushed onto a
// scoreboard queue as each step is driven and popped when the matching
// DUT output is sampled.
module tb_reg_file_cc;

  logic        Clk;
  logic        Reset_n;
  logic [15:0] BUS;
  logic [15:0] IR;
  logic        LD_REG;
  logic        LD_CC;
  logic        LD_BEN;
  logic        DRMUX;
  logic        SR1MUX;
  logic [15:0] SR1;
  logic [15:0] SR2;
  logic [2:0]  NZP;
  logic        BEN;

  typedef struct {
    string       tag;
    logic [15:0] value;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  reg_file_cc #(
    .WIDTH (16),
    .NREGS (8)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .BUS     (BUS),
    .IR      (IR),
    .LD_REG  (LD_REG),
    .LD_CC   (LD_CC),
    .LD_BEN  (LD_BEN),
    .DRMUX   (DRMUX),
    .SR1MUX  (SR1MUX),
    .SR1     (SR1),
    .SR2     (SR2),
    .NZP     (NZP),
    .BEN     (BEN)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance past the next rising edge and settle one time unit after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [15:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic check_output(input logic [15:0] observed);
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_empty: observed %h required an expected entry", observed);
      return;
    end
    e = sb.pop_front();
    vectors++;
    assert (observed === e.value)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", e.tag, observed, e.value);
    end
  endtask

  task automatic set_strobes(input logic ld_reg, input logic ld_cc, input logic ld_ben);
    LD_REG = ld_reg;
    LD_CC  = ld_cc;
    LD_BEN = ld_ben;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset_n = 1'b1;
    BUS     = 16'h0000;
    IR      = 16'h0000;
    DRMUX   = 1'b0;
    SR1MUX  = 1'b0;
    set_strobes(1'b0, 1'b0, 1'b0);

    // Reset asserted mid-cycle, checked before any clock edge.
    #2;
    Reset_n = 1'b0;
    #1;
    push_exp("reset_sr1", 16'h0000);  check_output(SR1);
    push_exp("reset_sr2", 16'h0000);  check_output(SR2);
    push_exp("reset_nzp", 16'h0002);  check_output({13'b0, NZP});
    push_exp("reset_ben", 16'h0000);  check_output({15'b0, BEN});
    tick();
    tick();
    Reset_n = 1'b1;

    // Write R5 = 1234; the same-cycle read of R5 still shows the old value.
    IR     = 16'h1A00;
    DRMUX  = 1'b0;
    SR1MUX = 1'b0;
    BUS    = 16'h1234;
    set_strobes(1'b1, 1'b0, 1'b0);
    #2;
    push_exp("no_bypass_sr1", 16'h0000);  check_output(SR1);
    tick();
    set_strobes(1'b0, 1'b0, 1'b0);
    push_exp("write_r5_after_edge", 16'h1234);  check_output(SR1);
    IR     = 16'h0140;
    SR1MUX = 1'b1;
    #1;
    push_exp("read_r5_via_ir86", 16'h1234);  check_output(SR1);

    // R7 write through DRMUX, read back on the SR2 port.
    DRMUX = 1'b1;
    BUS   = 16'h3001;
    set_strobes(1'b1, 1'b0, 1'b0);
    tick();
    set_strobes(1'b0, 1'b0, 1'b0);
    DRMUX = 1'b0;
    IR    = 16'h0007;
    #1;
    push_exp("r7_via_sr2", 16'h3001);  check_output(SR2);

    // Condition-code decode, including the 8000/0000 boundaries.
    set_strobes(1'b0, 1'b1, 1'b0);
    BUS = 16'h8000;
    tick();
    push_exp("cc_8000_n", 16'h0004);  check_output({13'b0, NZP});
    BUS = 16'h0000;
    tick();
    push_exp("cc_0000_z", 16'h0002);  check_output({13'b0, NZP});
    BUS = 16'h7FFF;
    tick();
    push_exp("cc_7fff_p", 16'h0001);  check_output({13'b0, NZP});
    set_strobes(1'b0, 1'b0, 1'b0);

    // BEN evaluation against NZP = 001.
    IR = 16'h0200;
    set_strobes(1'b0, 1'b0, 1'b1);
    tick();
    push_exp("ben_p_match", 16'h0001);  check_output({15'b0, BEN});
    IR = 16'h0C00;
    tick();
    push_exp("ben_nz_nomatch", 16'h0000);  check_output({15'b0, BEN});

    // Re-arm BEN=1, then load CC and BEN together: BEN must use the old P.
    IR = 16'h0200;
    tick();
    push_exp("ben_rearm", 16'h0001);  check_output({15'b0, BEN});
    IR  = 16'h0400;
    BUS = 16'h0000;
    set_strobes(1'b0, 1'b1, 1'b1);
    tick();
    set_strobes(1'b0, 1'b0, 1'b0);
    push_exp("simul_ben_old_nzp", 16'h0000);  check_output({15'b0, BEN});
    push_exp("simul_nzp_loaded", 16'h0002);   check_output({13'b0, NZP});

    // Dual-port reads: R3 = AAAA, R4 = 5555.
    SR1MUX = 1'b0;
    IR     = 16'h0600;
    BUS    = 16'hAAAA;
    set_strobes(1'b1, 1'b0, 1'b0);
    tick();
    IR  = 16'h0800;
    BUS = 16'h5555;
    tick();
    set_strobes(1'b0, 1'b0, 1'b0);
    BUS = 16'hFFFF;
    IR  = 16'h0604;
    tick();
    push_exp("dual_sr1_r3", 16'hAAAA);  check_output(SR1);
    push_exp("dual_sr2_r4", 16'h5555);  check_output(SR2);
    IR = 16'h0603;
    #1;
    push_exp("same_reg_sr1", 16'hAAAA);  check_output(SR1);
    push_exp("same_reg_sr2", 16'hAAAA);  check_output(SR2);

    // BEN=1 from Z, then reset mid-cycle with a write pending.
    IR = 16'h0400;
    set_strobes(1'b0, 1'b0, 1'b1);
    tick();
    push_exp("ben_z_match", 16'h0001);  check_output({15'b0, BEN});
    IR  = 16'h0600;
    BUS = 16'hBEEF;
    set_strobes(1'b1, 1'b1, 1'b1);
    #2;
    Reset_n = 1'b0;
    #1;
    push_exp("midreset_sr1", 16'h0000);  check_output(SR1);
    push_exp("midreset_sr2", 16'h0000);  check_output(SR2);
    push_exp("midreset_nzp", 16'h0002);  check_output({13'b0, NZP});
    push_exp("midreset_ben", 16'h0000);  check_output({15'b0, BEN});
    tick();
    push_exp("reset_ignores_ld", 16'h0000);  check_output(SR1);
    Reset_n = 1'b1;
    tick();
    set_strobes(1'b0, 1'b0, 1'b0);
    push_exp("first_load_after_reset", 16'hBEEF);  check_output(SR1);
    push_exp("first_cc_after_reset", 16'h0004);    check_output({13'b0, NZP});

    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
